// File: rtl/hidden_cpu_core_if.sv
// Instruction handshake bundle between an instruction source and hidden_cpu_core.
//   instr_valid : source holds a valid instruction on instr
//   instr       : {op[7:6], rd[5:4], rs[3:2], fn[1:0]}
//   instr_ready : core accepts instr this cycle; fire = instr_valid & instr_ready
// master modport: instruction source; slave modport: the core.
interface hidden_cpu_core_if;
  logic       instr_valid;
  logic [7:0] instr;
  logic       instr_ready;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready
  );
endinterface

// File: rtl/hidden_cpu_core.sv
// Hidden CPU core: four DATA_W-bit GPRs, carry flag, PC_W-bit program counter and a banked
// single-port data RAM. Executes one externally supplied 8-bit instruction per accepted
// handshake. After reset the RAM is zeroed one word per cycle before instructions are taken.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   instr_if   : slave side of the instruction valid/ready handshake
//   dout       : r3, or the program counter when the view bit is set
//   carry      : carry flag
module hidden_cpu_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PC_W   = 8,
  parameter int unsigned RAM_AW = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  hidden_cpu_core_if.slave   instr_if,
  output logic [DATA_W-1:0]  dout,
  output logic               carry
);

  localparam int unsigned BankW = RAM_AW - DATA_W;
  localparam int unsigned Depth = 1 << RAM_AW;

  typedef enum logic [1:0] {StClear, StRun, StLdWait} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   gpr_q [4];
  logic [DATA_W-1:0]   gpr_d [4];
  logic                carry_q, carry_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [BankW-1:0]    bank_q, bank_d;
  logic                view_q, view_d;
  logic [RAM_AW-1:0]   clr_addr_q, clr_addr_d;
  logic [1:0]          ld_rd_q, ld_rd_d;

  logic [DATA_W-1:0]   mem_q [Depth];
  logic [DATA_W-1:0]   ram_rdata_q;
  logic                ram_we, ram_re;
  logic [RAM_AW-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_wdata;

  // Instruction decode
  logic [1:0]          op, rd_idx, rs_idx, fn;
  logic [DATA_W-1:0]   rd_val, rs_val;
  logic                fire, is_ld;
  logic [DATA_W:0]     add_w, sub_w;
  logic [DATA_W:0]     cin_w;

  assign op     = instr_if.instr[7:6];
  assign rd_idx = instr_if.instr[5:4];
  assign rs_idx = instr_if.instr[3:2];
  assign fn     = instr_if.instr[1:0];
  assign rd_val = gpr_q[rd_idx];
  assign rs_val = gpr_q[rs_idx];
  assign fire   = instr_if.instr_valid && (state_q == StRun);
  assign is_ld  = (op == 2'b11) && (fn == 2'b00);

  // Only ADC/SBC consume the incoming carry; CMPA/CMP use the plain sum/difference.
  assign cin_w  = {{DATA_W{1'b0}}, carry_q & (fn == 2'b01)};
  assign add_w  = {1'b0, rd_val} + {1'b0, rs_val} + cin_w;
  // Top bit of the (DATA_W+1)-bit difference is the borrow.
  assign sub_w  = {1'b0, rd_val} - {1'b0, rs_val} - cin_w;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StClear;
      gpr_q[0]   <= DATA_W'(0);
      gpr_q[1]   <= DATA_W'(1);
      gpr_q[2]   <= DATA_W'(2);
      gpr_q[3]   <= DATA_W'(3);
      carry_q    <= 1'b0;
      pc_q       <= '0;
      bank_q     <= '0;
      view_q     <= 1'b0;
      clr_addr_q <= '0;
      ld_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      gpr_q      <= gpr_d;
      carry_q    <= carry_d;
      pc_q       <= pc_d;
      bank_q     <= bank_d;
      view_q     <= view_d;
      clr_addr_q <= clr_addr_d;
      ld_rd_q    <= ld_rd_d;
    end
  end

  // Single-port synchronous RAM, no reset; contents come from the clear sequence.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_addr] <= ram_wdata;
    end
    if (ram_re) begin
      ram_rdata_q <= mem_q[ram_addr];
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear:  if (clr_addr_q == {RAM_AW{1'b1}}) state_d = StRun;
      StRun:    if (fire && is_ld) state_d = StLdWait;
      StLdWait: state_d = StRun;
      default:  state_d = StClear;
    endcase
  end

  // Datapath next values
  always_comb begin
    gpr_d      = gpr_q;
    carry_d    = carry_q;
    pc_d       = pc_q;
    bank_d     = bank_q;
    view_d     = view_q;
    clr_addr_d = clr_addr_q;
    ld_rd_d    = ld_rd_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = {bank_q, rs_val};
    ram_wdata  = rd_val;

    unique case (state_q)
      StClear: begin
        ram_we     = 1'b1;
        ram_addr   = clr_addr_q;
        ram_wdata  = '0;
        clr_addr_d = clr_addr_q + RAM_AW'(1);
      end
      StLdWait: begin
        gpr_d[ld_rd_q] = ram_rdata_q;
      end
      StRun: begin
        if (fire) begin
          pc_d = pc_q + PC_W'(1);
          unique case (op)
            2'b00: begin
              unique case (fn)
                2'b00, 2'b01: begin
                  gpr_d[rd_idx] = add_w[DATA_W-1:0];
                  carry_d       = add_w[DATA_W];
                end
                2'b10: carry_d = add_w[DATA_W];
                2'b11: begin
                  gpr_d[rd_idx] = {rd_val[DATA_W-2:0], 1'b0};
                  carry_d       = rd_val[DATA_W-1];
                end
                default: ;
              endcase
            end
            2'b01: begin
              unique case (fn)
                2'b00, 2'b01: begin
                  gpr_d[rd_idx] = sub_w[DATA_W-1:0];
                  carry_d       = sub_w[DATA_W];
                end
                2'b10: carry_d = sub_w[DATA_W];
                2'b11: begin
                  gpr_d[rd_idx] = {1'b0, rd_val[DATA_W-1:1]};
                  carry_d       = rd_val[0];
                end
                default: ;
              endcase
            end
            2'b10: begin
              unique case (fn)
                2'b00:   gpr_d[rd_idx] = rd_val & rs_val;
                2'b01:   gpr_d[rd_idx] = rd_val | rs_val;
                2'b10:   gpr_d[rd_idx] = rd_val ^ rs_val;
                default: gpr_d[rd_idx] = rs_val;
              endcase
            end
            default: begin
              unique case (fn)
                2'b00: begin
                  ram_re  = 1'b1;
                  ld_rd_d = rd_idx;
                end
                2'b01: ram_we = 1'b1;
                2'b10: if (carry_q) pc_d = pc_q + PC_W'(rs_val);
                default: begin
                  unique case (rd_idx)
                    2'b00:   view_d  = ~view_q;
                    2'b01:   bank_d  = rs_val[BankW-1:0];
                    2'b10:   carry_d = 1'b0;
                    default: ;
                  endcase
                end
              endcase
            end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Outputs depend on registered state only
  always_comb begin
    instr_if.instr_ready = (state_q == StRun);
    dout                 = view_q ? DATA_W'(pc_q) : gpr_q[3];
    carry                = carry_q;
  end

endmodule
